frame_decode_pipe: RTL and testbench
====================================

# frame_decode_pipe

Parametrised successor to the two-car frame decoder. It resolves which object (map or one of `NUM_CARS` car sprites) owns each VGA pixel and issues the packed-SRAM word address. It then tracks that pixel through an SRAM read of configurable latency, unpacks the returned word and emits a 24-bit colour with a valid strobe. It sits between the VGA timing generator and the VGA DAC, and owns the only SRAM read port used for graphics.

## Interface
Parameters:
- `NUM_CARS`, 2: number of car sprites (1..4); car 0 has highest draw priority.
- `H_W`, 10: horizontal coordinate width. `V_W`, 9: vertical coordinate width.
- `MAP_W`, 640 / `MAP_H`, 480: map dimensions in pixels.
- `SPRITE`, 32: square sprite edge; power of two.
- `SRAM_LAT`, 1: cycles from `o_sram_addr` change to valid `i_sram_data` (1..4).
- `PPW`, 2: pixels packed per SRAM word (1 or 2). `DATA_W`, 16: SRAM word width. `ADDR_W`, 20: SRAM address width.
- `MASS_W`, 2: car mass-level width.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_pix_valid` in 1: `i_VGA_H`/`i_VGA_V` name a visible pixel this cycle.
- `i_VGA_H` in `H_W`, `i_VGA_V` in `V_W`: pixel coordinate.
- `i_frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `i_car_x` in `NUM_CARS*(H_W+1)`, signed per slice: sprite top-left x.
- `i_car_y` in `NUM_CARS*(V_W+1)`, signed per slice: sprite top-left y.
- `i_car_mass` in `NUM_CARS*MASS_W`: per-car mass level.
- `o_sram_addr` out `ADDR_W`: registered word address.
- `i_sram_data` in `DATA_W`: read data.
- `o_color` out 24: {R,G,B}.
- `o_color_valid` out 1: `o_color` corresponds to an accepted pixel.
- `o_object_id` out 3: 0 = map, k+1 = car k; aligned with `o_color`.

## Operation
- **Hit test.** Per car k: `dx = H - x_k` and `dy = V - y_k`, computed sign-extended at `H_W+2`/`V_W+2` bits. Hit when `0 <= dx < SPRITE` and `0 <= dy < SPRITE`. Partially off-screen sprites clip correctly. The lowest hitting k wins; with no hit, the object is the map.
- **Pixel index.**
  - Map: `V*MAP_W + H`.
  - Car: `dy*SPRITE + dx`.
- **Word address.**
  - Map: `index/PPW`.
  - Car k: `MAP_W*MAP_H/PPW + k*SPRITE*SPRITE/PPW + index/PPW`.
- **Sideband pipeline.** A delay line of depth `SRAM_LAT+1` carries valid, object id, `index % PPW`, and the mass of the winning car (0 for the map).
- **Unpack.** With `PPW=2`, sub-pixel 0 is `data[7:0]` and sub-pixel 1 is `data[15:8]`. With `PPW=1`, the pixel is `data[7:0]`.
- **Colour.** The 8-bit pixel is RGB332, expanded by bit replication: R = {r2,r1,r0,r2,r1,r0,r2,r1}, G likewise, B = {b1,b0,b1,b0,b1,b0,b1,b0}. For car pixels, `B |= mass << (8-MASS_W)`.
- **Invalid slots.** When `i_pix_valid`=0, the address still updates but the slot is marked invalid. The output then drives `o_color_valid`=0 and `o_color`=0.

## Timing
- Pixel accepted at cycle t:
  - `o_sram_addr` registered at t+1.
  - Data sampled at t+1+`SRAM_LAT`.
  - `o_color`, `o_color_valid` and `o_object_id` registered at t+2+`SRAM_LAT`.
- Total latency L = `SRAM_LAT`+2, at full throughput of one pixel per cycle. There is no backpressure.
- Reset: every pipeline register clears on the cycle `i_rst` is sampled high. Outputs are 0: `o_sram_addr`=0, `o_color`=0, `o_color_valid`=0, `o_object_id`=0. Pixels in flight are dropped; no valid output appears until L cycles after the first post-reset valid pixel.
- `i_frame_start` and `i_pix_valid` may be asserted on the same cycle. That pixel uses the pre-pulse car state.

## Configuration
- `FRAME_DECODE_SNAPSHOT_EN` defined:
  - `i_car_x`, `i_car_y` and `i_car_mass` are captured into shadow registers on `i_frame_start`.
  - Hit testing and tint use the shadow values from the following cycle onward, so no tearing occurs within a frame.
  - Shadows reset to 0.
- Not defined:
  - Live inputs are used directly.
  - The mass level travels in the sideband so the tint matches the sampled pixel.

## Test plan
- **Map pixel.** Defaults. No car hit, pixel (3,0) valid, `i_sram_data`=16'hE0_1C at t+2. Expect `o_sram_addr`=1 at t+1, then `o_color`=24'hFF0000, `o_object_id`=0, valid at t+3.
- **Priority overlap.** Car0 and car1 both at (100,50), mass0=3, pixel (101,50). Expect address = 153600+0+0 (index 1, word 0, sub 1), `o_object_id`=1, and blue OR 8'hC0 on the returned pixel.
- **Negative clipping.** Car0 x=-5, pixel H=0. Expect a hit with dx=5. Car0 x=-40, pixel H=0: expect map.
- **Latency sweep.** `SRAM_LAT`=3, a valid burst of 10 pixels, then a gap of 2. Expect 10 valids beginning at t+5 and the gap reproduced exactly, with colour/address pairing preserved.
- **Reset mid-flight.** Assert `i_rst` 1 cycle after a valid pixel. Expect all outputs 0 and no stale valid afterwards.
- **Snapshot (macro on).** Move car0 x 100→200 mid-frame. Expect hits to stay at 100 until the cycle after `i_frame_start`; a pixel coincident with the pulse still uses 100.

Source files
------------

// File: rtl/frame_decode_pipe.sv
// Pixel owner resolution (map / car sprites), packed-SRAM addressing and RGB332 -> RGB888 output.
// Define FRAME_DECODE_SNAPSHOT_EN to latch car state on i_frame_start instead of using live inputs.
module frame_decode_pipe #(
    parameter int unsigned NUM_CARS = 2,
    parameter int unsigned H_W      = 10,
    parameter int unsigned V_W      = 9,
    parameter int unsigned MAP_W    = 640,
    parameter int unsigned MAP_H    = 480,
    parameter int unsigned SPRITE   = 32,
    parameter int unsigned SRAM_LAT = 1,
    parameter int unsigned PPW      = 2,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned MASS_W   = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_pix_valid,
    input  logic [H_W-1:0]              i_VGA_H,
    input  logic [V_W-1:0]              i_VGA_V,
    input  logic                        i_frame_start,
    input  logic [NUM_CARS*(H_W+1)-1:0] i_car_x,
    input  logic [NUM_CARS*(V_W+1)-1:0] i_car_y,
    input  logic [NUM_CARS*MASS_W-1:0]  i_car_mass,
    output logic [ADDR_W-1:0]           o_sram_addr,
    input  logic [DATA_W-1:0]           i_sram_data,
    output logic [23:0]                 o_color,
    output logic                        o_color_valid,
    output logic [2:0]                  o_object_id
);
    localparam int unsigned DXW       = H_W + 2;
    localparam int unsigned DYW       = V_W + 2;
    localparam int unsigned SB_D      = SRAM_LAT + 1;
    localparam int unsigned CAR_BASE  = MAP_W * MAP_H / PPW;
    localparam int unsigned CAR_WORDS = SPRITE * SPRITE / PPW;

    typedef struct packed {
        logic              valid;
        logic [2:0]        obj;
        logic              sub;
        logic [MASS_W-1:0] mass;
    } sb_t;

    logic [NUM_CARS*(H_W+1)-1:0] car_x;
    logic [NUM_CARS*(V_W+1)-1:0] car_y;
    logic [NUM_CARS*MASS_W-1:0]  car_mass;

`ifdef FRAME_DECODE_SNAPSHOT_EN
    logic [NUM_CARS*(H_W+1)-1:0] car_x_q, car_x_d;
    logic [NUM_CARS*(V_W+1)-1:0] car_y_q, car_y_d;
    logic [NUM_CARS*MASS_W-1:0]  car_mass_q, car_mass_d;

    always_comb begin
        car_x_d    = car_x_q;
        car_y_d    = car_y_q;
        car_mass_d = car_mass_q;
        if (i_frame_start) begin
            car_x_d    = i_car_x;
            car_y_d    = i_car_y;
            car_mass_d = i_car_mass;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            car_x_q    <= '0;
            car_y_q    <= '0;
            car_mass_q <= '0;
        end else begin
            car_x_q    <= car_x_d;
            car_y_q    <= car_y_d;
            car_mass_q <= car_mass_d;
        end
    end

    // A pixel coincident with the pulse still sees the pre-pulse shadow.
    assign car_x    = car_x_q;
    assign car_y    = car_y_q;
    assign car_mass = car_mass_q;
`else
    logic unused_frame_start;
    assign unused_frame_start = i_frame_start;
    assign car_x    = i_car_x;
    assign car_y    = i_car_y;
    assign car_mass = i_car_mass;
`endif

    logic [DXW-1:0]    dx;
    logic [DYW-1:0]    dy;
    logic [31:0]       index_s0;
    logic [ADDR_W-1:0] addr_s0;
    logic [2:0]        obj_s0;
    logic              sub_s0;
    logic [MASS_W-1:0] mass_s0;

    // Descending scan so the lowest-numbered hitting car is written last and wins.
    always_comb begin
        obj_s0   = '0;
        mass_s0  = '0;
        dx       = '0;
        dy       = '0;
        index_s0 = 32'(i_VGA_V) * MAP_W + 32'(i_VGA_H);
        addr_s0  = ADDR_W'(index_s0 / PPW);
        for (int k = int'(NUM_CARS) - 1; k >= 0; k--) begin
            dx = {2'b00, i_VGA_H} - {car_x[k*(H_W+1)+H_W], car_x[k*(H_W+1) +: H_W+1]};
            dy = {2'b00, i_VGA_V} - {car_y[k*(V_W+1)+V_W], car_y[k*(V_W+1) +: V_W+1]};
            if (!dx[DXW-1] && (dx < DXW'(SPRITE)) && !dy[DYW-1] && (dy < DYW'(SPRITE))) begin
                obj_s0   = 3'(k + 1);
                mass_s0  = car_mass[k*MASS_W +: MASS_W];
                index_s0 = 32'(dy) * SPRITE + 32'(dx);
                addr_s0  = ADDR_W'(CAR_BASE + 32'(k) * CAR_WORDS + index_s0 / PPW);
            end
        end
        sub_s0 = (PPW == 2) ? index_s0[0] : 1'b0;
    end

    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    sb_t               sb_q [SB_D];
    sb_t               sb_d [SB_D];
    logic [23:0]       color_q, color_d;
    logic              color_valid_q, color_valid_d;
    logic [2:0]        object_id_q, object_id_d;
    sb_t               tail;
    logic [7:0]        pix, red, grn, blu;

    assign tail = sb_q[SB_D-1];

    always_comb begin
        sram_addr_d    = addr_s0;
        sb_d[0].valid  = i_pix_valid;
        sb_d[0].obj    = obj_s0;
        sb_d[0].sub    = sub_s0;
        sb_d[0].mass   = mass_s0;
        for (int i = 1; i < int'(SB_D); i++) begin
            sb_d[i] = sb_q[i-1];
        end

        pix = tail.sub ? 8'(i_sram_data >> 8) : i_sram_data[7:0];
        red = {pix[7:5], pix[7:5], pix[7:6]};
        grn = {pix[4:2], pix[4:2], pix[4:3]};
        blu = {4{pix[1:0]}};
        if (tail.obj != 3'd0) begin
            blu = blu | (8'(tail.mass) << (8 - MASS_W));
        end
        color_d       = tail.valid ? {red, grn, blu} : 24'd0;
        color_valid_d = tail.valid;
        object_id_d   = tail.valid ? tail.obj : 3'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sram_addr_q   <= '0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
            object_id_q   <= '0;
            for (int i = 0; i < int'(SB_D); i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            sram_addr_q   <= sram_addr_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            object_id_q   <= object_id_d;
            for (int i = 0; i < int'(SB_D); i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign o_sram_addr   = sram_addr_q;
    assign o_color       = color_q;
    assign o_color_valid = color_valid_q;
    assign o_object_id   = object_id_q;
endmodule

// File: tb/tb_frame_decode_pipe.sv
// Directed bench for frame_decode_pipe: one instance at SRAM_LAT=1, one at SRAM_LAT=3.
module tb_frame_decode_pipe;
    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic [9:0]  vga_h;
    logic [8:0]  vga_v;
    logic        frame_start;
    logic [21:0] car_x;
    logic [19:0] car_y;
    logic [3:0]  car_mass;

    logic [19:0] a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic [23:0] a_color, b_color;
    logic        a_valid, b_valid;
    logic [2:0]  a_obj, b_obj;

    int n_checks = 0;
    int n_fails  = 0;

    frame_decode_pipe #(.SRAM_LAT(1)) u_dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_valid   (pix_valid),
        .i_VGA_H       (vga_h),
        .i_VGA_V       (vga_v),
        .i_frame_start (frame_start),
        .i_car_x       (car_x),
        .i_car_y       (car_y),
        .i_car_mass    (car_mass),
        .o_sram_addr   (a_addr),
        .i_sram_data   (a_data),
        .o_color       (a_color),
        .o_color_valid (a_valid),
        .o_object_id   (a_obj)
    );

    frame_decode_pipe #(.SRAM_LAT(3)) u_dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_valid   (pix_valid),
        .i_VGA_H       (vga_h),
        .i_VGA_V       (vga_v),
        .i_frame_start (frame_start),
        .i_car_x       (car_x),
        .i_car_y       (car_y),
        .i_car_mass    (car_mass),
        .o_sram_addr   (b_addr),
        .i_sram_data   (b_data),
        .o_color       (b_color),
        .o_color_valid (b_valid),
        .o_object_id   (b_obj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        return {~a[7:0], a[7:0] ^ 8'h96};
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

    // Three-cycle SRAM model for the SRAM_LAT=3 instance.
    logic [15:0] b_lat [3];
    always @(posedge clk) begin
        b_lat[0] <= sram_word(b_addr);
        b_lat[1] <= b_lat[0];
        b_lat[2] <= b_lat[1];
    end
    assign b_data = b_lat[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cars(input int x0, input int y0, input int m0,
                            input int x1, input int y1, input int m1);
        car_x       = {11'(x1), 11'(x0)};
        car_y       = {10'(y1), 10'(y0)};
        car_mass    = {2'(m1), 2'(m0)};
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic run_pixel(input string tag, input int h, input int v,
                             input logic [19:0] exp_addr, input logic [2:0] exp_obj,
                             input logic [15:0] data, input logic [23:0] exp_color,
                             input logic fs);
        pix_valid   = 1'b1;
        vga_h       = 10'(h);
        vga_v       = 9'(v);
        frame_start = fs;
        step();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        check_eq({tag, ":addr"}, 32'(a_addr), 32'(exp_addr));
        step();
        check_eq({tag, ":early"}, 32'(a_valid), 32'd0);
        a_data = data;
        step();
        a_data = 16'hDEAD;
        check_eq({tag, ":valid"}, 32'(a_valid), 32'd1);
        check_eq({tag, ":color"}, 32'(a_color), 32'(exp_color));
        check_eq({tag, ":obj"}, 32'(a_obj), 32'(exp_obj));
        step();
        check_eq({tag, ":after"}, 32'(a_valid), 32'd0);
    endtask

    logic        exp_v [14];
    logic [23:0] exp_c [14];
    int          idx;
    logic [19:0] aw;
    logic [7:0]  pb;

    initial begin
        rst         = 1'b1;
        pix_valid   = 1'b0;
        vga_h       = '0;
        vga_v       = '0;
        frame_start = 1'b0;
        car_x       = '0;
        car_y       = '0;
        car_mass    = '0;
        a_data      = '0;
        step();
        step();
        check_eq("rst:addr", 32'(a_addr), 32'd0);
        check_eq("rst:color", 32'(a_color), 32'd0);
        check_eq("rst:valid", 32'(a_valid), 32'd0);
        check_eq("rst:obj", 32'(a_obj), 32'd0);
        rst = 1'b0;

        set_cars(100, 50, 3, 100, 50, 1);
        run_pixel("map", 3, 0, 20'd1, 3'd0, 16'hE01C, 24'hFF0000, 1'b0);
        run_pixel("prio", 101, 50, 20'd153600, 3'd1, 16'h1C00, 24'h00FFC0, 1'b0);
        run_pixel("edge31", 131, 81, 20'd154111, 3'd1, 16'h4A77, 24'h4949EA, 1'b0);
        run_pixel("edge32", 132, 50, 20'd16066, 3'd0, 16'hFF81, 24'h920055, 1'b0);
        run_pixel("dxneg", 99, 50, 20'd16049, 3'd0, 16'h1C00, 24'h00FF00, 1'b0);
        run_pixel("mapend", 639, 479, 20'd153599, 3'd0, 16'hE300, 24'hFF00FF, 1'b0);

        set_cars(-5, 0, 2, 300, 200, 1);
        run_pixel("clip5", 0, 0, 20'd153602, 3'd1, 16'h0000, 24'h000080, 1'b0);
        run_pixel("car1", 302, 201, 20'd154129, 3'd2, 16'hFF20, 24'h240040, 1'b0);

        set_cars(-40, 0, 3, 600, 0, 1);
        run_pixel("clip40", 0, 0, 20'd0, 3'd0, 16'h00E0, 24'hFF0000, 1'b0);

        // Reset one cycle after a valid pixel: that pixel must never emerge.
        pix_valid = 1'b1;
        vga_h     = 10'd3;
        vga_v     = 9'd0;
        step();
        pix_valid = 1'b0;
        rst       = 1'b1;
        step();
        rst    = 1'b0;
        a_data = 16'hE01C;
        check_eq("midrst:addr", 32'(a_addr), 32'd0);
        check_eq("midrst:color", 32'(a_color), 32'd0);
        check_eq("midrst:valid", 32'(a_valid), 32'd0);
        check_eq("midrst:obj", 32'(a_obj), 32'd0);
        step();
        check_eq("midrst:stale1", 32'(a_valid), 32'd0);
        step();
        check_eq("midrst:stale2", 32'(a_valid), 32'd0);
        check_eq("midrst:color2", 32'(a_color), 32'd0);

        // SRAM_LAT=3 burst: 10 valid, 2 idle, 2 valid; outputs expected 5 cycles later.
        set_cars(600, 400, 0, 600, 400, 0);
        for (int n = 0; n < 20; n++) begin
            if (n >= 5 && n < 19) begin
                check_eq($sformatf("burst_v%0d", n - 5), 32'(b_valid), 32'(exp_v[n-5]));
                check_eq($sformatf("burst_c%0d", n - 5), 32'(b_color), 32'(exp_c[n-5]));
            end else begin
                check_eq($sformatf("burst_idle%0d", n), 32'(b_valid), 32'd0);
            end
            if (n < 14) begin
                pix_valid = (n < 10) || (n >= 12);
                vga_h     = 10'(20 + n);
                vga_v     = 9'd10;
                idx       = 10 * 640 + 20 + n;
                aw        = 20'(idx / 2);
                pb        = (idx % 2 == 1) ? ~aw[7:0] : (aw[7:0] ^ 8'h96);
                exp_v[n]  = pix_valid;
                exp_c[n]  = pix_valid ? exp_rgb(pb) : 24'd0;
            end else begin
                pix_valid = 1'b0;
            end
            step();
        end

`ifdef FRAME_DECODE_SNAPSHOT_EN
        set_cars(100, 50, 3, 600, 400, 1);
        car_x[10:0] = 11'd200;
        run_pixel("snap_hold", 101, 50, 20'd153600, 3'd1, 16'h0000, 24'h0000C0, 1'b0);
        run_pixel("snap_pulse", 101, 50, 20'd153600, 3'd1, 16'h0000, 24'h0000C0, 1'b1);
        run_pixel("snap_new", 101, 50, 20'd16050, 3'd0, 16'h0000, 24'h000000, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
